// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data-memory controller state encoding and word width.
package cpu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    // Data-memory controller FSM states
    typedef enum logic [1:0] {
        DMC_IDLE = 2'd0,
        DMC_WAIT = 2'd1,
        DMC_DONE = 2'd2
    } dmc_state_e;

endpackage : cpu_pkg

// File: rtl/dm_byte_ram.sv
// Byte-organised data RAM with a big-endian 32-bit word view.
// Ports:
//   CLK    - clock; writes occur on posedge
//   we     - write enable for the addressed word
//   addr   - word-aligned byte address (low two bits expected 0)
//   wdata  - word to store, bits[31:24] go to the lowest byte address
//   rdata  - combinational big-endian read of the addressed word
module dm_byte_ram
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [BYTE_W-1:0] r_mem [DEPTH];

    logic [ADDR_W-1:0] w_a1;
    logic [ADDR_W-1:0] w_a2;
    logic [ADDR_W-1:0] w_a3;

    assign w_a1 = addr + ADDR_W'(1);
    assign w_a2 = addr + ADDR_W'(2);
    assign w_a3 = addr + ADDR_W'(3);

    // Big-endian store: most significant byte at the lowest address
    always_ff @(posedge CLK) begin
        if (we) begin
            r_mem[addr] <= wdata[31:24];
            r_mem[w_a1] <= wdata[23:16];
            r_mem[w_a2] <= wdata[15:8];
            r_mem[w_a3] <= wdata[7:0];
        end
    end

    assign rdata = {r_mem[addr], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};

endmodule : dm_byte_ram

// File: rtl/data_mem_ctrl.sv
// Wait-state data-memory stage for lw/sw between the ALU and write-back mux.
// Ports:
//   CLK     - system clock
//   Reset   - asynchronous active-low reset
//   mRD     - load request, held until Stall=0
//   mWR     - store request, held until Stall=0
//   DAddr   - byte address (upper bits beyond ADDR_W ignored)
//   DataIn  - store data
//   DataOut - registered load data
//   Stall   - combinational; holds PC/IR while an access is in flight
//   AccErr  - combinational; request rejected (misaligned or mRD&mWR)
module data_mem_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              mRD,
    input  logic              mWR,
    input  logic [WORD_W-1:0] DAddr,
    input  logic [WORD_W-1:0] DataIn,
    output logic [WORD_W-1:0] DataOut,
    output logic              Stall,
    output logic              AccErr
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    dmc_state_e        r_state;
    dmc_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [WORD_W-1:0] r_dout;
    logic              w_req;
    logic              w_access;
    logic [ADDR_W-1:0] w_idx;
    logic [WORD_W-1:0] w_rdata;
    logic              w_unused_addr;

    // Request decode: exactly one of load/store, word aligned
    assign w_req  = (mRD ^ mWR) & (DAddr[1:0] == 2'b00);
    assign AccErr = (mRD & mWR) | ((mRD | mWR) & (DAddr[1:0] != 2'b00));

    // Upper address bits are dropped so accesses wrap modulo the memory depth
    assign w_idx         = {DAddr[ADDR_W-1:2], 2'b00};
    assign w_unused_addr = ^DAddr[WORD_W-1:ADDR_W];

    dm_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .CLK   (CLK),
        .we    (w_access & mWR),
        .addr  (w_idx),
        .wdata (DataIn),
        .rdata (w_rdata)
    );

    // State, counter and load-data registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= DMC_IDLE;
            r_cnt   <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_access && mRD) begin
                r_dout <= w_rdata;
            end
        end
    end

    // Next-state, counter and stall decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_access    = 1'b0;
        Stall       = 1'b0;
        case (r_state)
            DMC_IDLE: begin
                Stall = w_req;
                if (w_req) begin
                    if (WAIT_STATES == 0) begin
                        w_access    = 1'b1;
                        w_state_nxt = DMC_DONE;
                    end else begin
                        w_cnt_nxt   = CNT_INIT;
                        w_state_nxt = DMC_WAIT;
                    end
                end
            end
            DMC_WAIT: begin
                Stall = 1'b1;
                if (!w_req) begin
                    w_state_nxt = DMC_IDLE;
                end else if (r_cnt == '0) begin
                    w_access    = 1'b1;
                    w_state_nxt = DMC_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            DMC_DONE: begin
                w_state_nxt = DMC_IDLE;
            end
            default: begin
                w_state_nxt = DMC_IDLE;
            end
        endcase
    end

    assign DataOut = r_dout;

endmodule : data_mem_ctrl

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
    import cpu_pkg::*;

    localparam int unsigned AW    = 7;
    localparam int unsigned WS    = 2;
    localparam int unsigned DEPTH = 128;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        mrd = 1'b0, mwr = 1'b0;
    logic [31:0] daddr = '0, din = '0;
    logic [31:0] dout;
    logic        stall, err;

    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] addr0 = '0, din0 = '0;
    logic [31:0] dout0;
    logic        stall0, err0;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]  model [DEPTH];
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
        .CLK(clk), .Reset(rst_n), .mRD(mrd), .mWR(mwr), .DAddr(daddr),
        .DataIn(din), .DataOut(dout), .Stall(stall), .AccErr(err)
    );

    data_mem_ctrl #(.ADDR_W(AW), .WAIT_STATES(0)) dut0 (
        .CLK(clk), .Reset(rst_n), .mRD(rd0), .mWR(wr0), .DAddr(addr0),
        .DataIn(din0), .DataOut(dout0), .Stall(stall0), .AccErr(err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference memory: address taken modulo depth, rounded down to a word
    function automatic int unsigned word_base(input logic [31:0] a);
        int unsigned b;
        b = a % DEPTH;
        return b - (b % 4);
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [31:0] d);
        int unsigned b;
        b = word_base(a);
        for (int k = 0; k < 4; k++) model[b + k] = 8'((d >> (8 * (3 - k))) & 32'hFF);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a);
        int unsigned b;
        logic [31:0] w;
        b = word_base(a);
        w = '0;
        for (int k = 0; k < 4; k++) w = (w << 8) | 32'(model[b + k]);
        return w;
    endfunction

    // One full transaction on the WAIT_STATES=2 instance; entered just after a posedge
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input string name);
        int n;
        logic [31:0] exp;
        mrd = rd; mwr = wr; daddr = a; din = d;
        n = 0;
        #1;
        while (stall === 1'b1 && n < 20) begin
            n++;
            @(posedge clk); #2;
        end
        check({name, " stall cycles"}, 32'(n), 32'(WS + 1));
        check({name, " done stall"}, 32'(stall), 32'd0);
        if (rd) begin
            exp = model_load(a);
            check({name, " load data"}, dout, exp);
            last_rd = exp;
        end
        if (wr) model_store(a, d);
        @(posedge clk); #1;
        mrd = 1'b0; mwr = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic        exp_err;
        logic        exp_stall;
    } dec_vec_t;

    dec_vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0A, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h04, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h05, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h08, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 32'h0C, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 32'h03, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 32'h83, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 32'h00, 1'b1, 1'b0};

        // Reset state
        #1;
        check("reset dout", dout, 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset state", 32'(dut.r_state), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill every word so the reference model is fully defined
        for (int i = 0; i < int'(DEPTH / 4); i++)
            do_access(1'b0, 1'b1, 32'(i * 4), $urandom, "prefill");

        // Store then load, with byte-order check
        do_access(1'b0, 1'b1, 32'h08, 32'hDEADBEEF, "sw 0x08");
        do_access(1'b1, 1'b0, 32'h08, 32'h0, "lw 0x08");
        check("byte mem[0x08]", 32'(dut.u_ram.r_mem[8]), 32'hDE);
        check("byte mem[0x0B]", 32'(dut.u_ram.r_mem[11]), 32'hEF);

        // Idle-state request decode
        for (int i = 0; i < 8; i++) begin
            mrd = vecs[i].rd; mwr = vecs[i].wr; daddr = vecs[i].addr;
            #1;
            check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            mrd = 1'b0; mwr = 1'b0;
            @(posedge clk); #1;
        end

        // Rejected requests held across edges
        mrd = 1'b1; daddr = 32'h0A;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("misaligned err", 32'(err), 32'd1);
            check("misaligned stall", 32'(stall), 32'd0);
            check("misaligned dout", dout, last_rd);
        end
        mrd = 1'b1; mwr = 1'b1; daddr = 32'h04; din = 32'hFFFF0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rd&wr err", 32'(err), 32'd1);
        end
        mrd = 1'b0; mwr = 1'b0;
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 32'h04, 32'h0, "lw 0x04 after rd&wr");

        // Address wrap
        do_access(1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, "sw 0x80");
        do_access(1'b1, 1'b0, 32'h00, 32'h0, "lw 0x00 wrap");
        check("wrap value", last_rd, 32'hA5A5A5A5);

        // Store dropped while waiting
        mwr = 1'b1; daddr = 32'h20; din = 32'h11223344;
        @(posedge clk); #1;
        mwr = 1'b0;
        #1;
        check("drop wait stall", 32'(stall), 32'd1);
        @(posedge clk); #2;
        check("drop idle stall", 32'(stall), 32'd0);
        check("drop idle state", 32'(dut.r_state), 32'd0);
        do_access(1'b1, 1'b0, 32'h20, 32'h0, "lw 0x20 after drop");

        // Reset in the middle of a store
        mwr = 1'b1; daddr = 32'h10; din = 32'h12345678;
        @(posedge clk); #1;
        check("pre-reset state", 32'(dut.r_state), 32'd1);
        rst_n = 1'b0; mwr = 1'b0;
        #1;
        check("mid reset state", 32'(dut.r_state), 32'd0);
        check("mid reset dout", dout, 32'd0);
        check("mid reset stall", 32'(stall), 32'd0);
        for (int k = 0; k < 4; k++)
            check($sformatf("mid reset mem[0x%02h]", 16 + k),
                  32'(dut.u_ram.r_mem[16 + k]), 32'(model[16 + k]));
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_rd = '0;
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 32'h10, 32'h0, "lw 0x10 after reset");

        // Randomised traffic against the reference model
        for (int i = 0; i < 48; i++) begin
            logic r;
            r = 1'($urandom_range(0, 1));
            do_access(r, ~r, 32'($urandom_range(0, 63)) << 2, $urandom, "random");
        end

        // Zero wait states: one stall cycle then DONE
        wr0 = 1'b1; addr0 = 32'h0; din0 = 32'hCAFEF00D;
        #1; check("ws0 sw0 stall", 32'(stall0), 32'd1);
        @(posedge clk); #2; check("ws0 sw0 done", 32'(stall0), 32'd0);
        @(posedge clk); #1;
        addr0 = 32'h4; din0 = 32'h0BADBEEF;
        #1; check("ws0 sw4 stall", 32'(stall0), 32'd1);
        @(posedge clk); #2; check("ws0 sw4 done", 32'(stall0), 32'd0);
        @(posedge clk); #1;
        wr0 = 1'b0; rd0 = 1'b1; addr0 = 32'h0;
        #1; check("b2b stall 1", 32'(stall0), 32'd1);
        @(posedge clk); #2;
        check("b2b stall 2", 32'(stall0), 32'd0);
        check("b2b dout 0x0", dout0, 32'hCAFEF00D);
        @(posedge clk); #1;
        addr0 = 32'h4;
        #1; check("b2b stall 3", 32'(stall0), 32'd1);
        @(posedge clk); #2;
        check("b2b stall 4", 32'(stall0), 32'd0);
        check("b2b dout 0x4", dout0, 32'h0BADBEEF);
        @(posedge clk); #1;
        rd0 = 1'b0;
        #1; check("ws0 idle stall", 32'(stall0), 32'd0);
        check("ws0 err", 32'(err0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_data_mem_ctrl
